fir_controller: RTL and testbench

- Sequencing FSM for the 4-tap FIR datapath.
- Sits directly downstream of the coefficient loader: consumes its load_coeff / coefficient_num strobes and returns modwait to it.
- On each new sample (data_ready), shifts the sample history, loads the new sample, then runs a 4-tap multiply-accumulate with alternating signs.
- Drives datapath op/src1/src2/dest each cycle; flags arithmetic overflow as an error.

---
 rtl/fir_ctrl_pkg.sv | 44 ++++
 rtl/fir_controller.sv | 132 +++++++++++++
 tb/tb_fir_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared encodings for the 4-tap FIR sequencing controller
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_COPY  = 3'd1,
    OP_LOAD1 = 3'd2,
    OP_LOAD2 = 3'd3,
    OP_ADD   = 3'd4,
    OP_SUB   = 3'd5,
    OP_MUL   = 3'd6
  } op_t;

  localparam int R_ACC = 1;
  localparam int R_S0  = 2;
  localparam int R_S1  = 3;
  localparam int R_S2  = 4;
  localparam int R_S3  = 5;
  localparam int R_F0  = 6;
  localparam int R_F1  = 7;
  localparam int R_F2  = 8;
  localparam int R_F3  = 9;
  localparam int R_TMP = 10;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOADC = 4'd1,
    SH3   = 4'd2,
    SH2   = 4'd3,
    SH1   = 4'd4,
    STORE = 4'd5,
    ZERO  = 4'd6,
    MUL1  = 4'd7,
    ADD1  = 4'd8,
    MUL2  = 4'd9,
    SUB2  = 4'd10,
    MUL3  = 4'd11,
    ADD3  = 4'd12,
    MUL4  = 4'd13,
    SUB4  = 4'd14,
    EIDLE = 4'd15
  } state_t;

endpackage

// File: rtl/fir_controller.sv
// rtl/fir_controller.sv - sample shift / 4-tap alternating-sign MAC sequencer
module fir_controller
  import fir_ctrl_pkg::*;
#(
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               data_ready,
  input  logic               load_coeff,
  input  logic [1:0]         coefficient_num,
  input  logic               overflow,
  output logic               cnt_up,
  output logic               clear,
  output logic               modwait,
  output logic [2:0]         op,
  output logic [RADDR_W-1:0] src1,
  output logic [RADDR_W-1:0] src2,
  output logic [RADDR_W-1:0] dest,
  output logic               err
);

  state_t     state_q, state_d;
  logic       modwait_q, modwait_d;
  logic [1:0] cidx_q, cidx_d;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      modwait_q <= 1'b0;
      cidx_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      modwait_q <= modwait_d;
      cidx_q    <= cidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    case (state_q)
      IDLE, EIDLE: begin
        if (data_ready) begin
          state_d = SH3;
        end else if (load_coeff) begin
          state_d = LOADC;
          cidx_d  = coefficient_num;
        end
      end
      LOADC: state_d = IDLE;
      SH3:   state_d = SH2;
      SH2:   state_d = SH1;
      SH1:   state_d = STORE;
      STORE: state_d = ZERO;
      ZERO:  state_d = overflow ? EIDLE : MUL1;
      MUL1:  state_d = ADD1;
      ADD1:  state_d = overflow ? EIDLE : MUL2;
      MUL2:  state_d = SUB2;
      SUB2:  state_d = overflow ? EIDLE : MUL3;
      MUL3:  state_d = ADD3;
      ADD3:  state_d = overflow ? EIDLE : MUL4;
      MUL4:  state_d = SUB4;
      SUB4:  state_d = overflow ? EIDLE : IDLE;
      default: state_d = IDLE;
    endcase
    // Registered so the loader sees busy for the whole cycle the sequence occupies.
    modwait_d = !(state_d inside {IDLE, EIDLE});
  end

  op_t op_w;

  always_comb begin
    op_w   = OP_NOP;
    src1   = '0;
    src2   = '0;
    dest   = '0;
    cnt_up = 1'b0;
    err    = 1'b0;
    case (state_q)
      LOADC: begin
        op_w = OP_LOAD2;
        dest = RADDR_W'(R_F0 + int'(cidx_q));
      end
      SH3: begin
        op_w = OP_COPY; src1 = RADDR_W'(R_S2); dest = RADDR_W'(R_S3);
      end
      SH2: begin
        op_w = OP_COPY; src1 = RADDR_W'(R_S1); dest = RADDR_W'(R_S2);
      end
      SH1: begin
        op_w = OP_COPY; src1 = RADDR_W'(R_S0); dest = RADDR_W'(R_S1);
      end
      STORE: begin
        op_w = OP_LOAD1; dest = RADDR_W'(R_S0);
      end
      ZERO: begin
        op_w   = OP_SUB;
        src1   = RADDR_W'(R_ACC);
        src2   = RADDR_W'(R_ACC);
        dest   = RADDR_W'(R_ACC);
        cnt_up = 1'b1;
      end
      MUL1: begin
        op_w = OP_MUL; src1 = RADDR_W'(R_S0); src2 = RADDR_W'(R_F0); dest = RADDR_W'(R_TMP);
      end
      MUL2: begin
        op_w = OP_MUL; src1 = RADDR_W'(R_S1); src2 = RADDR_W'(R_F1); dest = RADDR_W'(R_TMP);
      end
      MUL3: begin
        op_w = OP_MUL; src1 = RADDR_W'(R_S2); src2 = RADDR_W'(R_F2); dest = RADDR_W'(R_TMP);
      end
      MUL4: begin
        op_w = OP_MUL; src1 = RADDR_W'(R_S3); src2 = RADDR_W'(R_F3); dest = RADDR_W'(R_TMP);
      end
      ADD1, ADD3, SUB2, SUB4: begin
        // Even taps add, odd taps subtract the product held in the temp register.
        op_w = (state_q inside {ADD1, ADD3}) ? OP_ADD : OP_SUB;
        src1 = RADDR_W'(R_ACC);
        src2 = RADDR_W'(R_TMP);
        dest = RADDR_W'(R_ACC);
      end
      EIDLE: err = 1'b1;
      default: ;
    endcase
  end

  assign op      = op_w;
  assign modwait = modwait_q;
  assign clear   = 1'b0;

endmodule

// File: tb/tb_fir_controller.sv
// tb/tb_fir_controller.sv - randomized self-checking bench for fir_controller
module tb_fir_controller;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       data_ready = 1'b0;
  logic       load_coeff = 1'b0;
  logic [1:0] coefficient_num = 2'd0;
  logic       overflow = 1'b0;
  logic       cnt_up, clear, modwait, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  int pass_cnt = 0;
  int total_cnt = 0;

  fir_controller #(.RADDR_W(4)) dut (
    .clk(clk), .n_reset(n_reset), .data_ready(data_ready),
    .load_coeff(load_coeff), .coefficient_num(coefficient_num),
    .overflow(overflow), .cnt_up(cnt_up), .clear(clear), .modwait(modwait),
    .op(op), .src1(src1), .src2(src2), .dest(dest), .err(err)
  );

  always #5 clk = ~clk;

  // Per-cycle program of one sample: shift, load, zero, then tap k = S(k)*F(k), +,-,+,-.
  int e_op [13] = '{1, 1, 1, 2, 5, 6, 4, 6, 5, 6, 4, 6, 5};
  int e_s1 [13] = '{4, 3, 2, 0, 1, 2, 1, 3, 1, 4, 1, 5, 1};
  int e_s2 [13] = '{0, 0, 0, 0, 1, 6, 10, 7, 10, 8, 10, 9, 10};
  int e_dst[13] = '{5, 4, 3, 2, 1, 10, 1, 10, 1, 10, 1, 10, 1};

  function automatic bit ovf_sensitive(int k);
    return (k == 4) || (k == 6) || (k == 8) || (k == 10) || (k == 12);
  endfunction

  // Entered and left just after a negedge; leaves DUT in IDLE or EIDLE.
  task automatic run_sample(input int ovf_k, input string tag, output bit ended_err);
    logic [17:0] got, exp;
    ended_err = 1'b0;
    data_ready = 1'b1;
    overflow = 1'b0;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      data_ready = 1'b0;
      exp = {3'(e_op[k]), 4'(e_s1[k]), 4'(e_s2[k]), 4'(e_dst[k]), (k == 4), 1'b1, 1'b0};
      got = {op, src1, src2, dest, cnt_up, modwait, err};
      total_cnt++;
      if (got !== exp)
        $display("FAIL %s step %0d: got %h required %h", tag, k, got, exp);
      else
        pass_cnt++;
      overflow = (k == ovf_k);
      if (k == ovf_k && ovf_sensitive(k)) begin
        ended_err = 1'b1;
        break;
      end
    end
    @(negedge clk);
    overflow = 1'b0;
    exp = {3'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, ended_err};
    got = {op, src1, src2, dest, cnt_up, modwait, err};
    total_cnt++;
    if (got !== exp)
      $display("FAIL %s end: got %h required %h", tag, got, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_load(input logic [1:0] idx, input string tag);
    bit seen = 1'b0;
    load_coeff = 1'b1;
    coefficient_num = idx;
    for (int w = 0; w < 5 && !seen; w++) begin
      @(negedge clk);
      if (modwait === 1'b1) seen = 1'b1;
    end
    load_coeff = 1'b0;
    total_cnt++;
    if (!seen || {op, dest, err} !== {3'd3, 4'(6 + int'(idx)), 1'b0})
      $display("FAIL %s load: seen=%0d op=%0d dest=%0d err=%0d required op=3 dest=%0d err=0",
               tag, seen, op, dest, err, 6 + int'(idx));
    else
      pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({modwait, op} !== {1'b0, 3'd0})
      $display("FAIL %s release: modwait=%0d op=%0d required 0/0", tag, modwait, op);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    data_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total_cnt++;
      if ({op, modwait, err, cnt_up, clear} !== 7'd0)
        $display("FAIL reset: op=%0d modwait=%0d err=%0d cnt_up=%0d clear=%0d required all 0",
                 op, modwait, err, cnt_up, clear);
      else
        pass_cnt++;
    end
    n_reset = 1'b1;
    data_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({op, modwait, err} !== 5'd0)
      $display("FAIL reset_release: op=%0d modwait=%0d err=%0d required 0", op, modwait, err);
    else
      pass_cnt++;
  endtask

  task automatic test_load_single();
    coefficient_num = 2'd2;
    load_coeff = 1'b1;
    @(negedge clk);
    load_coeff = 1'b0;
    coefficient_num = 2'd0;
    total_cnt++;
    if ({op, dest, modwait} !== {3'd3, 4'd8, 1'b1})
      $display("FAIL load_single: op=%0d dest=%0d modwait=%0d required 3/8/1", op, dest, modwait);
    else
      pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({op, modwait} !== 4'd0)
      $display("FAIL load_single_done: op=%0d modwait=%0d required 0/0", op, modwait);
    else
      pass_cnt++;
  endtask

  task automatic test_coeff_handshake();
    for (int i = 0; i < 4; i++) begin
      do_load(2'(i), "handshake");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) do_load(2'($urandom_range(0, 3)), "handshake_rand");
  endtask

  task automatic test_sample();
    bit e;
    for (int n = 0; n < 3; n++) begin
      run_sample(-1, "sample", e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    run_sample(-1, "b2b_first", e);
    run_sample(-1, "b2b_second", e);
  endtask

  task automatic test_overflow();
    bit e;
    run_sample(10, "ovf_add3", e);
    @(negedge clk);
    total_cnt++;
    if ({err, op, modwait} !== {1'b1, 3'd0, 1'b0})
      $display("FAIL ovf_hold: err=%0d op=%0d modwait=%0d required 1/0/0", err, op, modwait);
    else
      pass_cnt++;
    run_sample(-1, "ovf_restart", e);
    run_sample(5, "ovf_ignored_mul", e);
    run_sample(1, "ovf_ignored_copy", e);
    run_sample(4, "ovf_zero", e);
    do_load(2'd1, "ovf_eidle_load");
  endtask

  task automatic test_random();
    bit e;
    for (int n = 0; n < 12; n++) begin
      run_sample(int'($urandom_range(0, 16)), "random", e);
      if (e && $urandom_range(0, 1) == 1) do_load(2'($urandom_range(0, 3)), "random_recover");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_priority();
    bit e;
    coefficient_num = 2'd3;
    load_coeff = 1'b1;
    run_sample(-1, "priority", e);
    @(negedge clk);
    load_coeff = 1'b0;
    total_cnt++;
    if ({op, dest, modwait} !== {3'd3, 4'd9, 1'b1})
      $display("FAIL priority_load: op=%0d dest=%0d modwait=%0d required 3/9/1", op, dest, modwait);
    else
      pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({op, modwait} !== 4'd0)
      $display("FAIL priority_done: op=%0d modwait=%0d required 0/0", op, modwait);
    else
      pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_load_single();
    test_coeff_handshake();
    test_sample();
    test_back_to_back();
    test_overflow();
    test_random();
    test_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
